// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared word and fetch-FSM state types for the MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    localparam word_t c_PC_STEP = 32'd4;

endpackage

`default_nettype wire

// File: rtl/if_id_latch.sv
// ============================================================================
// Module   : if_id_latch
// Brief    : IF/ID pipeline register with write enable and flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_latch
    import cpu_types_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_we,
    input  logic  i_flush,
    input  word_t i_instr,
    input  word_t i_npc,
    output word_t o_instr,
    output word_t o_npc,
    output logic  o_valid
);

    word_t r_instr;
    word_t r_npc;
    logic  r_valid;

    // Flush outranks write so a squashed slot never carries a live word.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_instr <= '0;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else if (i_we) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_npc   = r_npc;
    assign o_valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch: PC, one-deep stall buffer, redirect, halt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
)(
    input  logic  CLK,
    input  logic  RST,
    input  logic  ihit,
    input  word_t imemload,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ifW,
    input  logic  ifRST,
    input  logic  redir_en,
    input  word_t redir_pc,
    input  logic  halt,
    output word_t ifid_instr,
    output word_t ifid_npc,
    output logic  ifid_valid,
    output logic  halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    word_t        r_pc;
    word_t        w_pc_next;
    word_t        w_pc_plus4;
    word_t        r_buf_instr;
    word_t        r_buf_npc;
    logic         w_buf_load;
    logic         w_buf_clear;
    logic         w_if_we;
    logic         w_if_flush;
    word_t        w_if_instr;
    word_t        w_if_npc;

    assign w_pc_plus4 = r_pc + c_PC_STEP;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_buf_load   = 1'b0;
        w_buf_clear  = 1'b0;
        w_if_we      = 1'b0;
        w_if_flush   = 1'b0;
        w_if_instr   = imemload;
        w_if_npc     = w_pc_plus4;
        case (r_state)
            FETCH, HOLD: begin
                // Halt outranks everything, including a redirect and a flush.
                if (halt) begin
                    w_state_next = HALT;
                end else begin
                    w_if_flush = ifRST;
                    if (redir_en) begin
                        w_pc_next    = {redir_pc[31:2], 2'b00};
                        w_buf_clear  = 1'b1;
                        w_state_next = FETCH;
                    end else if (r_state == FETCH) begin
                        // A flushed fetch is dropped and refetched from the same PC.
                        if (ihit && !ifRST) begin
                            w_pc_next = w_pc_plus4;
                            if (ifW) begin
                                w_if_we = 1'b1;
                            end else begin
                                w_buf_load   = 1'b1;
                                w_state_next = HOLD;
                            end
                        end
                    end else if (ifW && !ifRST) begin
                        w_if_we      = 1'b1;
                        w_if_instr   = r_buf_instr;
                        w_if_npc     = r_buf_npc;
                        w_state_next = FETCH;
                    end
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= FETCH;
            r_pc        <= PC_INIT;
            r_buf_instr <= '0;
            r_buf_npc   <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_buf_clear) begin
                r_buf_instr <= '0;
                r_buf_npc   <= '0;
            end else if (w_buf_load) begin
                r_buf_instr <= imemload;
                r_buf_npc   <= w_pc_plus4;
            end
        end
    end

    assign imemREN  = !RST && (r_state == FETCH);
    assign imemaddr = r_pc;
    assign halted   = (r_state == HALT);

    if_id_latch u_if_id_latch (
        .clk     (CLK),
        .rst     (RST),
        .i_we    (w_if_we),
        .i_flush (w_if_flush),
        .i_instr (w_if_instr),
        .i_npc   (w_if_npc),
        .o_instr (ifid_instr),
        .o_npc   (ifid_npc),
        .o_valid (ifid_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;
    import cpu_types_pkg::*;

    logic  clk;
    logic  RST;
    logic  ihit;
    word_t imemload;
    logic  ifW;
    logic  ifRST;
    logic  redir_en;
    word_t redir_pc;
    logic  halt;

    logic  imemREN;
    word_t imemaddr;
    word_t ifid_instr;
    word_t ifid_npc;
    logic  ifid_valid;
    logic  halted;

    logic  w_imemREN;
    word_t w_imemaddr;
    word_t w_ifid_instr;
    word_t w_ifid_npc;
    logic  w_ifid_valid;
    logic  w_halted;

    int errors = 0;
    int checks = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) u_dut (
        .CLK(clk), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .ifW(ifW), .ifRST(ifRST),
        .redir_en(redir_en), .redir_pc(redir_pc), .halt(halt),
        .ifid_instr(ifid_instr), .ifid_npc(ifid_npc),
        .ifid_valid(ifid_valid), .halted(halted)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_wrap (
        .CLK(clk), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(w_imemREN), .imemaddr(w_imemaddr), .ifW(ifW), .ifRST(ifRST),
        .redir_en(redir_en), .redir_pc(redir_pc), .halt(halt),
        .ifid_instr(w_ifid_instr), .ifid_npc(w_ifid_npc),
        .ifid_valid(w_ifid_valid), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 0; imemload = '0; ifW = 0; ifRST = 0;
        redir_en = 0; redir_pc = '0; halt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        step();
        step();
        RST = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        step();
        step();
        checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b want 0", imemREN); end
        checks++; if (imemaddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", imemaddr); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
        checks++; if (ifid_instr !== 32'h0 || ifid_npc !== 32'h0) begin errors++; $display("FAIL reset_ifid: got %h/%h want 0/0", ifid_instr, ifid_npc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        RST = 0;
        #1;
        checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL reset_release_ren: got %b want 1", imemREN); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ihit = 1; ifW = 1; imemload = 32'h2001_0001 + k;
            checks++; if (imemaddr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr%0d: got %h want %h", k, imemaddr, 32'(4 * k)); end
            if (k == 0) begin
                checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_early: got %b want 0", ifid_valid); end
            end
            step();
            checks++; if (ifid_npc !== 32'(4 * k + 4)) begin errors++; $display("FAIL stream_npc%0d: got %h want %h", k, ifid_npc, 32'(4 * k + 4)); end
            checks++; if (ifid_instr !== 32'h2001_0001 + k || ifid_valid !== 1'b1) begin errors++; $display("FAIL stream_instr%0d: got %h v=%b want %h v=1", k, ifid_instr, ifid_valid, 32'h2001_0001 + k); end
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        do_reset();
        ihit = 1; ifW = 1; imemload = 32'h1111_0000;
        step();
        imemload = 32'h1111_0004;
        step();
        ifW = 0; imemload = 32'hAAAA_AAAA;
        checks++; if (imemaddr !== 32'h8) begin errors++; $display("FAIL hold_start_addr: got %h want 00000008", imemaddr); end
        step();
        ihit = 0; imemload = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            checks++; if (imemREN !== 1'b0) begin errors++; $display("FAIL hold_ren%0d: got %b want 0", k, imemREN); end
            checks++; if (ifid_instr !== 32'h1111_0004 || ifid_npc !== 32'h8) begin errors++; $display("FAIL hold_ifid%0d: got %h/%h want 11110004/00000008", k, ifid_instr, ifid_npc); end
            step();
        end
        ifW = 1;
        checks++; if (imemREN !== 1'b0 || ifid_instr !== 32'h1111_0004) begin errors++; $display("FAIL hold_release_pre: got ren=%b %h want ren=0 11110004", imemREN, ifid_instr); end
        step();
        checks++; if (ifid_instr !== 32'hAAAA_AAAA || ifid_npc !== 32'hC || ifid_valid !== 1'b1) begin errors++; $display("FAIL hold_release: got %h/%h v=%b want aaaaaaaa/0000000c v=1", ifid_instr, ifid_npc, ifid_valid); end
        checks++; if (imemaddr !== 32'hC || imemREN !== 1'b1) begin errors++; $display("FAIL hold_next_addr: got %h ren=%b want 0000000c ren=1", imemaddr, imemREN); end
        idle_inputs();
    endtask

    task automatic test_redirect();
        do_reset();
        ihit = 1; ifW = 1; imemload = 32'h2222_0000;
        step();
        redir_en = 1; redir_pc = 32'h0000_0103; ifRST = 1; imemload = 32'h5555_5555;
        step();
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("FAIL redir_flush: got v=%b %h want v=0 00000000", ifid_valid, ifid_instr); end
        checks++; if (imemaddr !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h want 00000100", imemaddr); end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        redir_en = 1; redir_pc = 32'h1C;
        step();
        redir_en = 0; ihit = 1; ifW = 1; imemload = 32'h3333_001C;
        step();
        checks++; if (ifid_valid !== 1'b1 || ifid_npc !== 32'h20 || imemaddr !== 32'h20) begin errors++; $display("FAIL flush_setup: got v=%b npc=%h addr=%h want v=1 npc=20 addr=20", ifid_valid, ifid_npc, imemaddr); end
        ifRST = 1; imemload = 32'h3333_0020;
        step();
        checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_npc !== 32'h0) begin errors++; $display("FAIL flush_ifid: got v=%b %h/%h want v=0 0/0", ifid_valid, ifid_instr, ifid_npc); end
        checks++; if (imemaddr !== 32'h20) begin errors++; $display("FAIL flush_addr: got %h want 00000020", imemaddr); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        checks++; if (w_imemaddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_init: got %h want fffffffc", w_imemaddr); end
        ihit = 1; ifW = 1; imemload = 32'h4444_4444;
        step();
        checks++; if (w_ifid_npc !== 32'h0 || w_ifid_valid !== 1'b1) begin errors++; $display("FAIL wrap_npc: got %h v=%b want 00000000 v=1", w_ifid_npc, w_ifid_valid); end
        checks++; if (w_imemaddr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 00000000", w_imemaddr); end
        idle_inputs();
    endtask

    task automatic test_halt();
        do_reset();
        ihit = 1; ifW = 1; imemload = 32'h6666_0000;
        step();
        halt = 1; redir_en = 1; redir_pc = 32'h200; imemload = 32'h6666_0004;
        step();
        checks++; if (halted !== 1'b1 || imemREN !== 1'b0) begin errors++; $display("FAIL halt_state: got halted=%b ren=%b want 1/0", halted, imemREN); end
        checks++; if (imemaddr !== 32'h4 || ifid_npc !== 32'h4 || ifid_instr !== 32'h6666_0000) begin errors++; $display("FAIL halt_frozen: got addr=%h npc=%h instr=%h want 4/4/66660000", imemaddr, ifid_npc, ifid_instr); end
        halt = 0; redir_pc = 32'h300; ifRST = 1;
        step();
        step();
        checks++; if (halted !== 1'b1 || imemaddr !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL halt_sticky: got halted=%b addr=%h v=%b want 1/4/1", halted, imemaddr, ifid_valid); end
        idle_inputs();
        RST = 1;
        step();
        checks++; if (halted !== 1'b0 || imemaddr !== 32'h0 || ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_reset: got halted=%b addr=%h v=%b want 0/0/0", halted, imemaddr, ifid_valid); end
        RST = 0;
        #1;
        checks++; if (imemREN !== 1'b1) begin errors++; $display("FAIL halt_reset_ren: got %b want 1", imemREN); end
    endtask

    initial begin
        RST = 1;
        idle_inputs();
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_flush();
        test_wrap();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
